// File: rtl/seg_pkg.sv
// Shared digit codes, FSM state type and elaboration helpers for bin_to_seg_digits.
package seg_pkg;

   localparam logic [3:0] DIGIT_BLANK = 4'd10;
   localparam logic [3:0] DIGIT_ERR   = 4'd15;

   typedef logic [3:0] digit_t;

   typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} b2s_state_t;

   // Largest magnitude that fits on n decimal displays.
   function automatic longint unsigned pow10_minus1(input int unsigned n);
      longint unsigned p;
      p = 64'd1;
      for (int unsigned i = 0; i < n; i++) begin
         p = p * 64'd10;
      end
      return p - 64'd1;
   endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_add3
   import seg_pkg::*;
(
   input  digit_t digit_in,
   output digit_t digit_out
);

   assign digit_out = (digit_in >= 4'd5) ? digit_in + 4'd3 : digit_in;

endmodule

// File: rtl/bin_to_seg_digits.sv
// Serial signed-binary to seven-segment digit-code encoder (double dabble, one bit per clock).
// Define LEADING_ZERO_BLANK_EN for leading-zero blanking with a floating minus sign.
module bin_to_seg_digits
   import seg_pkg::*;
#(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned DIGITS = 6
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [WIDTH-1:0]      value,
   output logic                  busy,
   output logic                  done,
   output logic [DIGITS*4-1:0]   digits,
   output logic [DIGITS-1:0]     neg_mask,
   output logic                  ovf
);

   localparam int unsigned     BCD_W   = DIGITS * 4;
   localparam int unsigned     CNT_W   = $clog2(WIDTH + 1);
   localparam longint unsigned MAX_MAG = pow10_minus1(DIGITS);

   b2s_state_t         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_adj;
   logic [WIDTH-1:0]   sh_q, sh_d;
   logic               sign_q, sign_d;
   logic               mag_ovf_q, mag_ovf_d;
   logic [BCD_W-1:0]   digits_q, digits_d;
   logic [DIGITS-1:0]  neg_q, neg_d;
   logic               ovf_q, ovf_d;
   logic               done_q, done_d;

   logic [WIDTH-1:0]   mag_in;
   logic [BCD_W-1:0]   fmt_digits;
   logic [DIGITS-1:0]  fmt_neg;
   logic               fmt_ovf;

   // Two's-complement negate; the most negative value maps to its true unsigned magnitude.
   assign mag_in = value[WIDTH-1] ? (~value + WIDTH'(1)) : value;

   for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .digit_in  (bcd_q[4*g +: 4]),
         .digit_out (bcd_adj[4*g +: 4])
      );
   end

`ifdef LEADING_ZERO_BLANK_EN
   int unsigned msd;
`endif

   always_comb begin
      fmt_ovf = mag_ovf_q;
      fmt_neg = '0;
      fmt_digits = bcd_q;
`ifdef LEADING_ZERO_BLANK_EN
      msd = 0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (bcd_q[4*i +: 4] != 4'd0) msd = i;
      end
      for (int unsigned i = 1; i < DIGITS; i++) begin
         if (i > msd) fmt_digits[4*i +: 4] = DIGIT_BLANK;
      end
      if (sign_q) begin
         if (msd == DIGITS - 1) begin
            fmt_ovf = 1'b1;
         end else begin
            fmt_digits[4*(msd+1) +: 4] = DIGIT_BLANK;
            fmt_neg[msd+1] = 1'b1;
         end
      end
`else
      if (sign_q) begin
         if (bcd_q[BCD_W-1 -: 4] != 4'd0) begin
            fmt_ovf = 1'b1;
         end else begin
            fmt_digits[BCD_W-1 -: 4] = DIGIT_BLANK;
            fmt_neg[DIGITS-1] = 1'b1;
         end
      end
`endif
      if (fmt_ovf) begin
         fmt_digits = {DIGITS{DIGIT_ERR}};
         fmt_neg = '0;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bcd_d     = bcd_q;
      sh_d      = sh_q;
      sign_d    = sign_q;
      mag_ovf_d = mag_ovf_q;
      digits_d  = digits_q;
      neg_d     = neg_q;
      ovf_d     = ovf_q;
      done_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = SHIFT;
               sign_d    = value[WIDTH-1];
               sh_d      = mag_in;
               bcd_d     = '0;
               cnt_d     = '0;
               mag_ovf_d = (64'(mag_in) > MAX_MAG);
            end
         end
         SHIFT: begin
            {bcd_d, sh_d} = {bcd_adj, sh_q} << 1;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FORMAT;
         end
         FORMAT: begin
            digits_d = fmt_digits;
            neg_d    = fmt_neg;
            ovf_d    = fmt_ovf;
            done_d   = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bcd_q     <= '0;
         sh_q      <= '0;
         sign_q    <= 1'b0;
         mag_ovf_q <= 1'b0;
         digits_q  <= {DIGITS{DIGIT_BLANK}};
         neg_q     <= '0;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bcd_q     <= bcd_d;
         sh_q      <= sh_d;
         sign_q    <= sign_d;
         mag_ovf_q <= mag_ovf_d;
         digits_q  <= digits_d;
         neg_q     <= neg_d;
         ovf_q     <= ovf_d;
         done_q    <= done_d;
      end
   end

   assign busy     = (state_q != IDLE);
   assign done     = done_q;
   assign digits   = digits_q;
   assign neg_mask = neg_q;
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_bin_to_seg_digits.sv
// Randomised bench for bin_to_seg_digits: a 6-digit and a 4-digit instance checked every cycle
// against a decimal-arithmetic reference model.
module tb_bin_to_seg_digits;

   localparam int W = 16;
`ifdef LEADING_ZERO_BLANK_EN
   localparam bit BLANK = 1'b1;
`else
   localparam bit BLANK = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               reset_n = 1'b0;
   logic               start = 1'b0;
   logic signed [15:0] value = '0;

   logic        busy6, done6, ovf6;
   logic [23:0] dig6;
   logic [5:0]  neg6;
   logic        busy4, done4, ovf4;
   logic [15:0] dig4;
   logic [3:0]  neg4;

   int n_checks = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   bin_to_seg_digits #(.WIDTH(16), .DIGITS(6)) u_dut6 (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .value    (value),
      .busy     (busy6),
      .done     (done6),
      .digits   (dig6),
      .neg_mask (neg6),
      .ovf      (ovf6)
   );

   bin_to_seg_digits #(.WIDTH(16), .DIGITS(4)) u_dut4 (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .value    (value),
      .busy     (busy4),
      .done     (done4),
      .digits   (dig4),
      .neg_mask (neg4),
      .ovf      (ovf4)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   // Display contents from the decimal expansion of the value.
   function automatic void model(input int v, input int nd, output logic [23:0] dg,
                                 output logic [5:0] nm, output logic ov);
      int  mag, lim, p, msd;
      int  d[6];
      bit  neg;
      neg = (v < 0);
      mag = neg ? -v : v;
      lim = 1;
      for (int i = 0; i < nd; i++) lim = lim * 10;
      lim = lim - 1;
      p = 1;
      msd = 0;
      for (int i = 0; i < nd; i++) begin
         d[i] = (mag / p) % 10;
         p = p * 10;
         if (d[i] != 0) msd = i;
      end
      dg = '0;
      nm = '0;
      ov = (mag > lim);
      if (neg && BLANK && msd == nd - 1) ov = 1'b1;
      if (neg && !BLANK && d[nd-1] != 0) ov = 1'b1;
      if (ov) begin
         for (int i = 0; i < nd; i++) dg[4*i +: 4] = 4'd15;
         return;
      end
      for (int i = 0; i < nd; i++) dg[4*i +: 4] = (BLANK && i > msd) ? 4'd10 : 4'(d[i]);
      if (neg) begin
         if (BLANK) begin
            dg[4*(msd+1) +: 4] = 4'd10;
            nm[msd+1] = 1'b1;
         end else begin
            dg[4*(nd-1) +: 4] = 4'd10;
            nm[nd-1] = 1'b1;
         end
      end
   endfunction

   // Timing model: an accepted request completes W+1 edges later; starts while busy are dropped.
   int                 remaining;
   logic signed [15:0] pend;
   logic               exp_busy, exp_done, exp_ovf6, exp_ovf4;
   logic [23:0]        exp_dig6;
   logic [5:0]         exp_neg6;
   logic [15:0]        exp_dig4;
   logic [3:0]         exp_neg4;

   initial begin
      logic        s_rst, s_start;
      logic [15:0] s_val;
      logic [23:0] t_dig;
      logic [5:0]  t_neg;
      remaining = 0;
      forever begin
         @(posedge clk);
         s_rst = reset_n;
         s_start = start;
         s_val = value;
         if (!s_rst) begin
            remaining = 0;
            exp_done = 1'b0;
            exp_dig6 = 24'hAAAAAA;
            exp_neg6 = '0;
            exp_ovf6 = 1'b0;
            exp_dig4 = 16'hAAAA;
            exp_neg4 = '0;
            exp_ovf4 = 1'b0;
         end else begin
            exp_done = 1'b0;
            if (remaining > 0) begin
               remaining--;
               if (remaining == 0) begin
                  model(int'(pend), 6, exp_dig6, exp_neg6, exp_ovf6);
                  model(int'(pend), 4, t_dig, t_neg, exp_ovf4);
                  exp_dig4 = t_dig[15:0];
                  exp_neg4 = t_neg[3:0];
                  exp_done = 1'b1;
               end
            end else if (s_start) begin
               pend = s_val;
               remaining = W + 1;
            end
         end
         exp_busy = (remaining > 0);
         @(negedge clk);
         check("busy6", 64'(busy6), 64'(exp_busy));
         check("done6", 64'(done6), 64'(exp_done));
         check("digits6", 64'(dig6), 64'(exp_dig6));
         check("neg6", 64'(neg6), 64'(exp_neg6));
         check("ovf6", 64'(ovf6), 64'(exp_ovf6));
         check("busy4", 64'(busy4), 64'(exp_busy));
         check("done4", 64'(done4), 64'(exp_done));
         check("digits4", 64'(dig4), 64'(exp_dig4));
         check("neg4", 64'(neg4), 64'(exp_neg4));
         check("ovf4", 64'(ovf4), 64'(exp_ovf4));
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Pulse start for one edge and wait (bounded) for done; returns edges from start to done.
   task automatic conv(input int v, output int lat);
      value = 16'(v);
      start = 1'b1;
      step();
      start = 1'b0;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (done6) begin
            lat = i;
            break;
         end
      end
      if (lat < 0) begin
         n_checks++;
         $display("FAIL done_timeout: no done within 40 edges for value %0d", v);
      end
   endtask

   initial begin
      int          lat, r, v;
      logic [23:0] md;
      logic [5:0]  mn;
      logic        mo;

      reset_n = 1'b0;
      repeat (3) step();
      check("rst_busy", 64'(busy6), 64'd0);
      check("rst_done", 64'(done6), 64'd0);
      check("rst_digits", 64'(dig6), 64'hAAAAAA);
      check("rst_neg", 64'(neg6), 64'd0);
      check("rst_ovf", 64'(ovf6), 64'd0);
      reset_n = 1'b1;
      step();

      // Pin the reference model with hand-worked cases.
      model(-42, 6, md, mn, mo);
      check("model_m42", 64'({md, mn, mo}), BLANK ? 64'({24'hAAAA42, 6'b000100, 1'b0})
                                                  : 64'({24'hA00042, 6'b100000, 1'b0}));
      model(0, 6, md, mn, mo);
      check("model_zero", 64'(md), BLANK ? 64'hAAAAA0 : 64'h000000);
      model(-1000, 4, md, mn, mo);
      check("model_m1000_ovf", 64'({md[15:0], mo}), 64'({16'hFFFF, 1'b1}));
      model(-32768, 6, md, mn, mo);
      check("model_min", 64'({md, mn}), 64'({24'hA32768, 6'b100000}));

      conv(1234, lat);
      check("lat_1234", 64'(lat), 64'd17);
      check("dig_1234", 64'(dig6), BLANK ? 64'hAA1234 : 64'h001234);
      check("neg_1234", 64'(neg6), 64'd0);
      conv(-42, lat);
      check("dig_m42", 64'(dig6), BLANK ? 64'hAAAA42 : 64'hA00042);
      check("neg_m42", 64'(neg6), BLANK ? 64'b000100 : 64'b100000);
      conv(0, lat);
      check("dig_zero", 64'(dig6), BLANK ? 64'hAAAAA0 : 64'h000000);
      conv(-32768, lat);
      check("dig_min", 64'(dig6), 64'hA32768);
      check("neg_min", 64'(neg6), 64'b100000);
      check("ovf_min", 64'(ovf6), 64'd0);
      conv(-999, lat);
      check("dig4_m999", 64'(dig4), 64'hA999);
      check("neg4_m999", 64'(neg4), 64'b1000);
      conv(-1000, lat);
      check("dig4_m1000", 64'({dig4, neg4, ovf4}), 64'({16'hFFFF, 4'b0000, 1'b1}));
      conv(12345, lat);
      check("dig4_12345", 64'({dig4, ovf4}), 64'({16'hFFFF, 1'b1}));
      check("dig6_12345", 64'(dig6), BLANK ? 64'hA12345 : 64'h012345);

      // A second start mid-conversion must be dropped.
      value = 16'sd100;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (4) step();
      value = -16'sd7;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (20) step();
      check("ignored_start", 64'(dig6), BLANK ? 64'hAAA100 : 64'h000100);

      // Reset in the middle of SHIFT aborts with no done.
      value = 16'sd555;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (8) step();
      reset_n = 1'b0;
      step();
      check("abort_busy", 64'(busy6), 64'd0);
      check("abort_digits", 64'(dig6), 64'hAAAAAA);
      reset_n = 1'b1;
      repeat (25) step();

      // start held high: re-accepted in each done cycle.
      start = 1'b1;
      for (int i = 0; i < 60; i++) begin
         value = 16'($urandom);
         step();
      end
      start = 1'b0;
      repeat (20) step();

      for (int n = 0; n < 150; n++) begin
         r = int'($urandom_range(0, 3));
         case (r)
            0: v = int'(16'($urandom)) - 32768;
            1: v = int'($urandom_range(0, 99)) * (($urandom_range(0, 1) != 0) ? -1 : 1);
            2: v = (($urandom_range(0, 1) != 0) ? 999 : 9999) + int'($urandom_range(0, 2));
            default: v = ($urandom_range(0, 1) != 0) ? -32768 : 32767;
         endcase
         if (r == 2 && $urandom_range(0, 1) != 0) v = -v;
         value = 16'(v);
         start = 1'b1;
         repeat ($urandom_range(1, 3)) step();
         start = 1'b0;
         if ($urandom_range(0, 29) == 0) begin
            reset_n = 1'b0;
            step();
            reset_n = 1'b1;
         end
         repeat ($urandom_range(0, 22)) step();
      end
      repeat (25) step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
